logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit for the ALU datapath.
- Generalises the fixed 6-bit OR path to WIDTH bits and 8 selectable bitwise operations.
- Adds a valid/ready handshake on input and output, one output register stage, and an internal accumulator so logic operations can be chained (Y = acc OP B).
- Sits between the operand/opcode decoder and the ALU result mux.

Parameters:
- WIDTH, 6, operand and result width in bits (≥1).
- OPW, 3, opcode width; fixed at 3, exposed for the package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  unit can accept this cycle
- op  in  OPW  operation select
- acc_mode  in  1  1: operand A replaced by accumulator
- acc_clr  in  1  synchronous accumulator clear
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- out_valid  out  1  Y holds a valid result
- out_ready  in  1  consumer accepts Y this cycle
- Y  out  WIDTH  registered result

Behaviour:
- One clock; reset is asynchronous and active-high (rst), clocked on rising clk.
- Reset values: out_valid=0, Y=0, acc=0. in_ready is combinational from out_valid, so it reads 1 during reset.
- Opcodes are applied to (opA, B), where opA = acc_mode ? acc : A:
  - 000 AND; 001 OR; 010 XOR; 011 NOR
  - 100 NAND; 101 XNOR; 110 NOT opA; 111 PASS B
- in_ready = !out_valid || out_ready (combinational; no comb path from in_valid to in_ready).
- Accept = in_valid && in_ready. On accept: Y <= result, out_valid <= 1, acc <= result.
- Latency: exactly 1 cycle from accept to out_valid=1.
- Throughput: 1 transaction per cycle while out_ready=1.
- Output drain: if out_valid && out_ready && !accept, then out_valid <= 0 and Y keeps its value.
- Stall: while out_valid && !out_ready, Y and out_valid hold and in_ready=0. Inputs are ignored and acc does not update.
- acc_clr:
  - Acts every cycle it is high, independent of in_valid.
  - If asserted in the same cycle as an accept, the result is computed with the old acc value, Y gets that result, and acc <= 0 (clear wins over update).
- acc_mode=0: A is used directly, but acc is still updated with the result. acc always holds the last accepted result.
- Results are exactly WIDTH bits; no carry, no overflow.
- rst asserted mid-transaction: the pending result is discarded and the block restarts from reset values.

Optional Feature:
- Macro: LOGIC_UNIT_PIPE_FLAGS_EN.
- When defined:
  - Adds output ports out_zero (1 bit) = (Y == 0) and out_par (1 bit) = ^Y.
  - Both are registered alongside Y, with reset value out_zero=1 and out_par=0.
  - They hold with Y during a stall.
- When undefined: the ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package logic_unit_pkg:
  - OPW=3.
  - Opcode constants OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_NOTA, OP_PASSB.
- Sub-module logic_unit_comb: a purely combinational (opA, B, op) -> result core, parametrised by WIDTH.
- The top module holds the handshake, accumulator and output registers.

Test Plan:
- Reset then A=6'b101010, B=6'b010101, op=OR, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, Y=6'b111111; following cycle out_valid=0.
- Back-to-back AND, XOR, NOR, then PASS B (one per cycle, out_ready=1), A=6'h3C, B=6'h0F -> Y = 6'h0C, 6'h33, 6'h00, 6'h0F on consecutive cycles.
- Hold out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 -> in_ready=0, Y stable, acc unchanged; release -> queued input accepted on the release cycle.
- Accumulator chain, acc_mode=1:
  - OR B=6'h01, then OR B=6'h04, then XOR B=6'h05 -> Y = 6'h01, 6'h05, 6'h00.
  - acc_clr in the same cycle as a fourth op (OR B=6'h02) -> Y = 6'h02, acc = 0 afterwards.
- Assert rst asynchronously mid-cycle while out_valid=1 -> out_valid, Y and acc go to 0 immediately, without waiting for clk.
- With LOGIC_UNIT_PIPE_FLAGS_EN, result 6'b000111 -> out_zero=0, out_par=1; result 0 -> out_zero=1, out_par=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared opcode width and opcode encodings for the logic unit
// Contents: OPW (opcode width) and the op_e opcode enumeration.
package logic_unit_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_NAND  = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

endpackage

// File: rtl/logic_unit_comb.sv
// rtl/logic_unit_comb.sv - purely combinational bitwise operation core
// Ports:
//   op_a_i   : first operand (A or accumulator, chosen by the caller)
//   b_i      : second operand
//   op_i     : operation select (op_e encoding)
//   result_o : WIDTH-bit result
module logic_unit_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OPW-1:0]   op_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_e'(op_i))
      OP_AND:   result_o = op_a_i & b_i;
      OP_OR:    result_o = op_a_i | b_i;
      OP_XOR:   result_o = op_a_i ^ b_i;
      OP_NOR:   result_o = ~(op_a_i | b_i);
      OP_NAND:  result_o = ~(op_a_i & b_i);
      OP_XNOR:  result_o = ~(op_a_i ^ b_i);
      OP_NOTA:  result_o = ~op_a_i;
      OP_PASSB: result_o = b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered WIDTH-bit logic unit with valid/ready handshake and accumulator
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : input handshake; in_ready depends only on output state
//   op, acc_mode        : operation select; acc_mode=1 uses the accumulator as operand A
//   acc_clr             : clears the accumulator every cycle it is high
//   A, B                : operands
//   out_valid/out_ready : output handshake
//   Y                   : registered result
//   out_zero, out_par   : registered zero / parity flags of Y (only with LOGIC_UNIT_PIPE_FLAGS_EN)
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int OPW_P = OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW_P-1:0] op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  output logic             out_zero,
  output logic             out_par,
`endif
  output logic [WIDTH-1:0] Y
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic             accept;

  // The output register can take a new value when empty or being drained.
  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign op_a     = acc_mode ? acc_q : A;

  logic_unit_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .op_a_i   (op_a),
    .b_i      (B),
    .op_i     (op),
    .result_o (result)
  );

  always_comb begin
    y_d   = y_q;
    vld_d = vld_q;
    acc_d = acc_q;
    if (accept) begin
      y_d   = result;
      vld_d = 1'b1;
      acc_d = result;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
    // Clear overrides the update; the result itself used the old acc.
    if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      vld_q <= 1'b0;
      acc_q <= '0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
      acc_q <= acc_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = vld_q;

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  logic zero_q, zero_d;
  logic par_q, par_d;

  always_comb begin
    zero_d = zero_q;
    par_d  = par_q;
    if (accept) begin
      zero_d = (result == '0);
      par_d  = ^result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
      par_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign out_zero = zero_q;
  assign out_par  = par_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe (LOGIC_UNIT_PIPE_FLAGS_EN aware)
module tb_logic_unit_pipe;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         acc_mode;
  logic         acc_clr;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  logic         out_zero;
  logic         out_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the consumer should see, and the accumulator.
  logic         m_vld;
  logic [W-1:0] m_y;
  logic [W-1:0] m_acc;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    .out_zero  (out_zero),
    .out_par   (out_par),
`endif
    .Y         (Y)
  );

  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] b);
    logic [W-1:0] ones;
    ones = '1;
    case (o)
      3'd0: return x & b;
      3'd1: return x | b;
      3'd2: return x ^ b;
      3'd3: return ones ^ (x | b);
      3'd4: return ones ^ (x & b);
      3'd5: return ones ^ (x ^ b);
      3'd6: return ones ^ x;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic am, input logic clr,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    in_valid  = v;
    op        = o;
    acc_mode  = am;
    acc_clr   = clr;
    A         = a;
    B         = b;
    out_ready = ordy;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, m_vld});
    chk({tag, "_y"}, {26'd0, Y}, {26'd0, m_y});
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, (m_y == 0)});
    chk({tag, "_par"}, {31'd0, out_par}, {31'd0, ^m_y});
`endif
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic cycle(input string tag);
    logic rdy;
    logic [W-1:0] res;
    #1;
    rdy = !m_vld || out_ready;
    chk({tag, "_rdy"}, {31'd0, in_ready}, {31'd0, rdy});
    if (in_valid && rdy) begin
      res   = ref_op(op, acc_mode ? m_acc : A, B);
      m_y   = res;
      m_vld = 1'b1;
      m_acc = res;
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
    if (acc_clr) m_acc = '0;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    m_vld = 1'b0;
    m_y   = '0;
    m_acc = '0;
    rst   = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("reset_rdy", {31'd0, in_ready}, 32'd1);
    check_outputs("reset");
    rst = 1'b0;

    // Single OR
    drive(1'b1, 3'd1, 1'b0, 1'b0, 6'b101010, 6'b010101, 1'b1);
    cycle("or");
    chk("or_const", {26'd0, Y}, 32'h3F);
    drive(1'b0, 3'd0, 1'b0, 1'b0, '0, '0, 1'b1);
    cycle("or_drain");
    chk("or_drain_vld", {31'd0, out_valid}, 32'd0);

    // Back-to-back AND, XOR, NOR, PASS B
    drive(1'b1, 3'd0, 1'b0, 1'b0, 6'h3C, 6'h0F, 1'b1);
    cycle("b2b_and");
    chk("b2b_and_const", {26'd0, Y}, 32'h0C);
    op = 3'd2;
    cycle("b2b_xor");
    chk("b2b_xor_const", {26'd0, Y}, 32'h33);
    op = 3'd3;
    cycle("b2b_nor");
    chk("b2b_nor_const", {26'd0, Y}, 32'h00);
    op = 3'd7;
    cycle("b2b_pass");
    chk("b2b_pass_const", {26'd0, Y}, 32'h0F);

    // Stall for 3 cycles with a pending input (NAND), then release
    drive(1'b1, 3'd4, 1'b0, 1'b0, 6'h3C, 6'h0F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall_y_hold", {26'd0, Y}, 32'h0F);
      chk("stall_rdy_low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    cycle("release");
    chk("release_const", {26'd0, Y}, 32'h33);

    // Accumulator chain, starting from a cleared accumulator
    drive(1'b0, 3'd0, 1'b0, 1'b1, '0, '0, 1'b1);
    cycle("clr_idle");
    drive(1'b1, 3'd1, 1'b1, 1'b0, 6'h2A, 6'h01, 1'b1);
    cycle("acc_or1");
    chk("acc_or1_const", {26'd0, Y}, 32'h01);
    B = 6'h04;
    cycle("acc_or4");
    chk("acc_or4_const", {26'd0, Y}, 32'h05);
    op = 3'd2; B = 6'h05;
    cycle("acc_xor5");
    chk("acc_xor5_const", {26'd0, Y}, 32'h00);
    op = 3'd1; B = 6'h02; acc_clr = 1'b1;
    cycle("acc_clr_or");
    chk("acc_clr_or_const", {26'd0, Y}, 32'h02);
    acc_clr = 1'b0; B = 6'h00;
    cycle("acc_after_clr");
    chk("acc_after_clr_const", {26'd0, Y}, 32'h00);

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    drive(1'b1, 3'd7, 1'b0, 1'b0, '0, 6'b000111, 1'b1);
    cycle("flag7");
    chk("flag7_zero", {31'd0, out_zero}, 32'd0);
    chk("flag7_par", {31'd0, out_par}, 32'd1);
    B = 6'h00;
    cycle("flag0");
    chk("flag0_zero", {31'd0, out_zero}, 32'd1);
    chk("flag0_par", {31'd0, out_par}, 32'd0);
`endif

    // Leave a result pending (stalled), then assert reset between edges
    drive(1'b1, 3'd7, 1'b0, 1'b0, '0, 6'h15, 1'b0);
    cycle("pre_rst");
    chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    m_vld = 1'b0; m_y = '0; m_acc = '0;
    chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("async_rst_y", {26'd0, Y}, 32'd0);
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    chk("async_rst_zero", {31'd0, out_zero}, 32'd1);
`endif
    @(negedge clk);
    rst = 1'b0;
    // Accumulator must read back as zero: acc OR 0
    drive(1'b1, 3'd1, 1'b1, 1'b0, 6'h3F, 6'h00, 1'b1);
    cycle("rst_acc");
    chk("rst_acc_const", {26'd0, Y}, 32'h00);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 7) == 0), W'($urandom), W'($urandom),
            ($urandom_range(0, 3) != 0));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
